// File: rtl/button_conditioner_if.sv
// Signal bundle between a raw push-button pad and its conditioner.
// The conditioner takes the slave side; the pad/stimulus side takes the master side.
interface button_conditioner_if;
    logic bouncy_i;
    logic debounced_o;
    logic press_o;
    logic release_o;
    logic long_o;
    logic repeat_o;

    modport master (
        output bouncy_i,
        input  debounced_o,
        input  press_o,
        input  release_o,
        input  long_o,
        input  repeat_o
    );

    modport slave (
        input  bouncy_i,
        output debounced_o,
        output press_o,
        output release_o,
        output long_o,
        output repeat_o
    );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchroniser, debounce FSM, press/release/long-press events.
// Optional auto-repeat pulses are enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000,
    parameter int REPEAT_CYCLES   = 2400000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    button_conditioner_if.slave btn
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    if ((DEBOUNCE_CYCLES < 2) || (LONG_CYCLES <= DEBOUNCE_CYCLES) || (REPEAT_CYCLES < 1)) begin : g_bad_cfg
        $error("button_conditioner: inconsistent cycle parameters");
    end

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic              pressed_raw_s;
    logic              sync_meta_r;
    logic              sync_r;
    state_t            state_r;
    state_t            state_next_s;
    logic [DB_W-1:0]   db_cnt_r;
    logic              db_done_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              hold_inc_s;
    logic              hold_hit_s;
    logic              long_done_r;
    logic              press_accept_s;
    logic              idle_entry_s;
    logic              debounced_next_s;
    logic              press_next_s;
    logic              release_next_s;
    logic              long_next_s;
    logic              repeat_next_s;
    logic              debounced_r;
    logic              press_r;
    logic              release_r;
    logic              long_r;
    logic              repeat_r;

    // Polarity correction ahead of the synchroniser keeps "released" as the reset value.
    assign pressed_raw_s = (ACTIVE_LOW != 0) ? ~btn.bouncy_i : btn.bouncy_i;

    // Two-flop synchroniser for the asynchronous pad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_r <= 1'b0;
            sync_r      <= 1'b0;
        end else begin
            sync_meta_r <= pressed_raw_s;
            sync_r      <= sync_meta_r;
        end
    end

    assign db_done_s = (db_cnt_r == DB_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sync_r) state_next_s = ST_PRESS_WAIT;
                else        state_next_s = ST_IDLE;
            end
            ST_PRESS_WAIT: begin
                if (!sync_r)        state_next_s = ST_IDLE;
                else if (db_done_s) state_next_s = ST_HELD;
                else                state_next_s = ST_PRESS_WAIT;
            end
            ST_HELD: begin
                if (!sync_r) state_next_s = ST_RELEASE_WAIT;
                else         state_next_s = ST_HELD;
            end
            ST_RELEASE_WAIT: begin
                if (sync_r)         state_next_s = ST_HELD;
                else if (db_done_s) state_next_s = ST_IDLE;
                else                state_next_s = ST_RELEASE_WAIT;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    assign press_accept_s = (state_r == ST_PRESS_WAIT) && (state_next_s == ST_HELD);
    assign idle_entry_s   = (state_r != ST_IDLE) && (state_next_s == ST_IDLE);

    // Debounce counter: restarts on every state change, saturates at the full count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r <= {DB_W{1'b0}};
        end else if (state_next_s != state_r) begin
            db_cnt_r <= {DB_W{1'b0}};
        end else if (((state_r == ST_PRESS_WAIT) || (state_r == ST_RELEASE_WAIT)) && (db_cnt_r != DB_MAX)) begin
            db_cnt_r <= db_cnt_r + DB_W'(1);
        end else begin
            db_cnt_r <= db_cnt_r;
        end
    end

    // Hold time only advances in HELD, so release-wait cycles push the long press later.
    assign hold_inc_s = (state_r == ST_HELD) && !long_done_r && (hold_cnt_r != HOLD_MAX);
    assign hold_hit_s = hold_inc_s && (hold_cnt_r == HOLD_LAST);

    // Hold counter and the once-per-press long flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r  <= {HOLD_W{1'b0}};
            long_done_r <= 1'b0;
        end else begin
            if (press_accept_s) begin
                hold_cnt_r <= {HOLD_W{1'b0}};
            end else if (hold_inc_s) begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end

            if (idle_entry_s) begin
                long_done_r <= 1'b0;
            end else if (hold_hit_s) begin
                long_done_r <= 1'b1;
            end else begin
                long_done_r <= long_done_r;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt_r;
    logic             rep_inc_s;
    logic             rep_hit_s;

    assign rep_inc_s = (state_r == ST_HELD) && long_done_r;
    assign rep_hit_s = rep_inc_s && (rep_cnt_r == REP_LAST);

    // Repeat counter runs after the long press, freezes while release is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_r <= {REP_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            rep_cnt_r <= {REP_W{1'b0}};
        end else if (rep_hit_s) begin
            rep_cnt_r <= {REP_W{1'b0}};
        end else if (rep_inc_s) begin
            rep_cnt_r <= rep_cnt_r + REP_W'(1);
        end else begin
            rep_cnt_r <= rep_cnt_r;
        end
    end

    assign repeat_next_s = rep_hit_s;
`else
    assign repeat_next_s = 1'b0;
`endif

    // FSM output decode, captured into output registers below.
    always_comb begin
        debounced_next_s = (state_next_s == ST_HELD) || (state_next_s == ST_RELEASE_WAIT);
        press_next_s     = press_accept_s;
        release_next_s   = (state_r == ST_RELEASE_WAIT) && (state_next_s == ST_IDLE);
        long_next_s      = hold_hit_s;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            debounced_r <= 1'b0;
            press_r     <= 1'b0;
            release_r   <= 1'b0;
            long_r      <= 1'b0;
            repeat_r    <= 1'b0;
        end else begin
            debounced_r <= debounced_next_s;
            press_r     <= press_next_s;
            release_r   <= release_next_s;
            long_r      <= long_next_s;
            repeat_r    <= repeat_next_s;
        end
    end

    assign btn.debounced_o = debounced_r;
    assign btn.press_o     = press_r;
    assign btn.release_o   = release_r;
    assign btn.long_o      = long_r;
    assign btn.repeat_o    = repeat_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner against a run-length reference model.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 8;

    logic clk = 1'b0;
    logic rst_n;

    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .REPEAT_CYCLES   (R),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // reference model: a pad-to-FSM delay of two edges, then a level that flips
    // after D+1 consecutive disagreeing samples; held time excludes release-wait time
    int m_s1, m_s2;
    int level, run, held_time;
    int exp_db, exp_press, exp_release, exp_long, exp_rep;

    int n_press, n_release, n_long, n_rep;
    int press_cyc, release_cyc, long_cyc, rep_first;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; level = 0; run = 0; held_time = 0;
        exp_db = 0; exp_press = 0; exp_release = 0; exp_long = 0; exp_rep = 0;
    endtask

    task automatic model_edge();
        int sync_v;
        int in_held;
        sync_v = m_s2;
        m_s2   = m_s1;
        m_s1   = (bus.bouncy_i == 1'b0) ? 1 : 0;
        exp_press = 0; exp_release = 0; exp_long = 0; exp_rep = 0;
        in_held = (level == 1) && (run == 0);
        if (sync_v != level) run++;
        else run = 0;
        if (run == D + 1) begin
            level = 1 - level;
            run   = 0;
            if (level == 1) begin
                exp_press = 1;
                held_time = 0;
            end else begin
                exp_release = 1;
            end
        end
        if (in_held) begin
            held_time++;
            if (held_time == L) exp_long = 1;
`ifdef BTN_AUTOREPEAT_EN
            if ((held_time > L) && (((held_time - L) % R) == 0)) exp_rep = 1;
`endif
        end
        exp_db = level;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check("debounced", bus.debounced_o, exp_db[0]);
        check("press",     bus.press_o,     exp_press[0]);
        check("release",   bus.release_o,   exp_release[0]);
        check("long",      bus.long_o,      exp_long[0]);
        check("repeat",    bus.repeat_o,    exp_rep[0]);
        if (bus.press_o)   begin n_press++;   press_cyc = cyc;   end
        if (bus.release_o) begin n_release++; release_cyc = cyc; end
        if (bus.long_o)    begin n_long++;    long_cyc = cyc;    end
        if (bus.repeat_o) begin
            n_rep++;
            if (rep_first < 0) rep_first = cyc;
        end
    endtask

    task automatic set_pressed(input bit p);
        bus.bouncy_i = p ? 1'b0 : 1'b1;
    endtask

    task automatic clear_marks();
        press_cyc = -1; release_cyc = -1; long_cyc = -1; rep_first = -1;
    endtask

    task automatic press_and_accept();
        set_pressed(1'b1);
        repeat (D + 3) step();
    endtask

    initial begin
        int t0, c_press, c_release, c_long, c_rep;
        n_press = 0; n_release = 0; n_long = 0; n_rep = 0;
        clear_marks();
        model_reset();

        // reset state
        rst_n = 1'b0;
        set_pressed(1'b0);
        #1;
        check("rst_debounced", bus.debounced_o, 1'b0);
        check("rst_press",     bus.press_o,     1'b0);
        check("rst_long",      bus.long_o,      1'b0);
        repeat (2) step();
        #3 rst_n = 1'b1;
        repeat (5) step();

        // clean press then release
        clear_marks();
        c_long = n_long;
        set_pressed(1'b1);
        t0 = cyc;
        repeat (12) step();
        check("clean_press_edge", press_cyc - t0 - 1, 6);
        set_pressed(1'b0);
        t0 = cyc;
        repeat (12) step();
        check("clean_release_edge", release_cyc - t0 - 1, 6);
        check("clean_no_long", n_long - c_long, 0);

        // bounce rejection
        c_press = n_press; c_release = n_release;
        for (int i = 0; i < 40; i++) begin
            set_pressed(((i / 3) % 2) == 0);
            step();
        end
        set_pressed(1'b0);
        repeat (8) step();
        check("bounce_no_press", n_press - c_press, 0);
        check("bounce_no_release", n_release - c_release, 0);

        // long press
        clear_marks();
        c_long = n_long; c_release = n_release;
        press_and_accept();
        while (cyc < press_cyc + 30) step();
        set_pressed(1'b0);
        repeat (10) step();
        check("long_count", n_long - c_long, 1);
        check("long_offset", long_cyc - press_cyc, L);
        check("long_release", n_release - c_release, 1);

        // auto-repeat
        clear_marks();
        c_rep = n_rep;
        press_and_accept();
        while (cyc < press_cyc + 50) step();
        set_pressed(1'b0);
        repeat (10) step();
`ifdef BTN_AUTOREPEAT_EN
        check("repeat_count", n_rep - c_rep, 4);
        check("repeat_first", rep_first - press_cyc, L + R);
`else
        check("repeat_count", n_rep - c_rep, 0);
`endif

        // two-cycle release glitch while held
        clear_marks();
        c_release = n_release;
        press_and_accept();
        while (cyc < press_cyc + 5) step();
        set_pressed(1'b0);
        repeat (2) step();
        set_pressed(1'b1);
        while (cyc < press_cyc + 30) step();
        check("glitch_no_release", n_release - c_release, 0);
        check("glitch_long_offset", long_cyc - press_cyc, L + 2);
        set_pressed(1'b0);
        repeat (10) step();

        // randomised episodes with bounce bursts
        for (int ep = 0; ep < 14; ep++) begin
            int nb;
            nb = $urandom_range(0, 4);
            for (int b = 0; b < nb; b++) begin
                set_pressed($urandom_range(0, 1) == 1);
                repeat ($urandom_range(1, 3)) step();
            end
            set_pressed((ep % 2) == 0);
            repeat ($urandom_range(1, 45)) step();
        end
        set_pressed(1'b0);
        repeat (10) step();

        // reset while held, input stays pressed
        clear_marks();
        press_and_accept();
        repeat (3) step();
        c_release = n_release;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_debounced", bus.debounced_o, 1'b0);
        check("midrst_press",     bus.press_o,     1'b0);
        repeat (3) step();
        #3 rst_n = 1'b1;
        clear_marks();
        t0 = cyc;
        repeat (10) step();
        check("midrst_refire_edge", press_cyc - t0 - 1, 6);
        check("midrst_no_release", n_release - c_release, 0);
        set_pressed(1'b0);
        repeat (10) step();

        // power-up with input released
        rst_n = 1'b0;
        model_reset();
        repeat (2) step();
        #3 rst_n = 1'b1;
        c_press = n_press; c_release = n_release; c_long = n_long; c_rep = n_rep;
        repeat (30) step();
        check("powerup_events",
              (n_press - c_press) + (n_release - c_release) + (n_long - c_long) + (n_rep - c_rep), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
